// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// Performance statistics for the pipelined CPU. It counts cycles, retired
// instructions and NUM_EVT single-bit event channels while in COUNT.
// Counting stops when a halt reaches writeback (DONE) or when the cycle
// watchdog expires (TIMEOUT). Counters saturate instead of wrapping.
// Any counter can be read through a registered select port.
module perf_counter_bank #(
   parameter int NUM_EVT    = 4,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 100000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               retire,
   input  logic               halt,
   input  logic [NUM_EVT-1:0] evt,
   input  logic               clear,
   input  logic [3:0]         rd_sel,
   output logic [CNT_W-1:0]   rd_data,
   output logic [1:0]         state_o,
   output logic               done,
   output logic               timeout
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COUNT   = 2'b01,
      ST_DONE    = 2'b10,
      ST_TIMEOUT = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // The watchdog compares the post-increment cycle count against this value.
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES + 1);

   // Saturating increment: the result holds at all-ones and never wraps.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic             inc);
      logic [CNT_W-1:0] result;
      if (inc && (value != CNT_MAX)) begin
         result = value + CNT_ONE;
      end else begin
         result = value;
      end
      return result;
   endfunction

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cyc;
   logic [CNT_W-1:0] r_ins;
   logic [CNT_W-1:0] r_evt [NUM_EVT];
   logic [CNT_W-1:0] w_cyc_next;
   logic [CNT_W-1:0] w_ins_next;
   logic             w_wd_trip;
   logic [CNT_W-1:0] w_rd_mux;
   logic [CNT_W-1:0] r_rd_data;
   logic             r_done;
   logic             r_timeout;

   // Next values of the cycle and instruction counters and the watchdog check.
   always_comb begin
      w_cyc_next = sat_inc(r_cyc, 1'b1);
      // A halt counts as an instruction; retire and halt together still add one.
      w_ins_next = sat_inc(r_ins, retire | halt);
      w_wd_trip  = (w_cyc_next == WD_LIMIT);
   end

   // Next-state logic; clear returns to IDLE from any state, halt beats the watchdog.
   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  w_state_next = ST_COUNT;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
            ST_COUNT: begin
               if (halt) begin
                  w_state_next = ST_DONE;
               end else if (w_wd_trip) begin
                  w_state_next = ST_TIMEOUT;
               end else begin
                  w_state_next = ST_COUNT;
               end
            end
            ST_DONE:    w_state_next = ST_DONE;
            ST_TIMEOUT: w_state_next = ST_TIMEOUT;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Status flags decoded from the next state so they rise with the state entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_done    <= (w_state_next == ST_DONE);
         r_timeout <= (w_state_next == ST_TIMEOUT);
      end
   end

   // Cycle and instruction counters advance only in COUNT, including the final cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_cyc <= CNT_ZERO;
         r_ins <= CNT_ZERO;
      end else if (r_state == ST_COUNT) begin
         r_cyc <= w_cyc_next;
         r_ins <= w_ins_next;
      end else begin
         r_cyc <= r_cyc;
         r_ins <= r_ins;
      end
   end

   // Event counters, one per channel, each saturating independently.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int i = 0; i < NUM_EVT; i++) begin
            r_evt[i] <= CNT_ZERO;
         end
      end else if (r_state == ST_COUNT) begin
         for (int i = 0; i < NUM_EVT; i++) begin
            r_evt[i] <= sat_inc(r_evt[i], evt[i]);
         end
      end else begin
         for (int i = 0; i < NUM_EVT; i++) begin
            r_evt[i] <= r_evt[i];
         end
      end
   end

   // Read mux over the current (pre-update) counter values; unmapped indices read zero.
   always_comb begin
      w_rd_mux = CNT_ZERO;
      case (rd_sel)
         4'd0:    w_rd_mux = r_cyc;
         4'd1:    w_rd_mux = r_ins;
         default: begin
            for (int i = 0; i < NUM_EVT; i++) begin
               w_rd_mux = w_rd_mux | (r_evt[i] & {CNT_W{rd_sel == 4'(i + 2)}});
            end
         end
      endcase
   end

   // Registered read data, one cycle after the select is presented.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_rd_data <= CNT_ZERO;
      end else begin
         r_rd_data <= w_rd_mux;
      end
   end

   assign rd_data = r_rd_data;
   assign state_o = r_state;
   assign done    = r_done;
   assign timeout = r_timeout;

endmodule
